// File: rtl/alarm_scheduler.sv
// Alarm scheduler: four BCD alarm slots, ring / snooze / idle sequencing.
// The optional macro ALARM_SCHED_AUTO_SNOOZE_EN makes a ring timeout act like a
// snooze press. When the macro is undefined, a ring timeout ends the event.
module alarm_scheduler #(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 540,
    parameter int MAX_SNOOZE  = 3
) (
    input  logic        clk,
    input  logic        rst_bar,
    input  logic        tick_1hz,
    input  logic [19:0] cur_time,
    input  logic        wr_en,
    input  logic [1:0]  wr_slot,
    input  logic [12:0] wr_hhmm,
    input  logic [3:0]  arm,
    input  logic        stop,
    input  logic        snooze,
    output logic        alarm,
    output logic [1:0]  active_slot,
    output logic        busy,
    output logic [1:0]  snooze_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RING   = 2'd1;
    localparam logic [1:0] ST_SNOOZE = 2'd2;

    localparam logic [9:0] RING_LAST   = 10'(RING_SECS - 1);
    localparam logic [9:0] SNOOZE_LAST = 10'(SNOOZE_SECS - 1);
    localparam logic [1:0] SNOOZE_MAX  = 2'(MAX_SNOOZE);

    logic [1:0]  state_reg, state_next;
    logic [9:0]  sec_cnt_reg, sec_cnt_next;
    logic [1:0]  slot_reg, slot_next;
    logic [1:0]  cnt_reg, cnt_next;
    logic        snooze_prev_reg;
    logic [12:0] slot_time_reg [4];
    logic [3:0]  hit;

    logic seconds_zero;
    logic snooze_press;
    logic ring_done;
    logic snooze_done;

    // Per-slot storage and match detection against the current hh:mm.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            // Slot register: loaded whenever its index is written, in any state.
            always_ff @(posedge clk or negedge rst_bar) begin
                if (!rst_bar) begin
                    slot_time_reg[gi] <= 13'd0;
                end else if (wr_en && (wr_slot == 2'(gi))) begin
                    slot_time_reg[gi] <= wr_hhmm;
                end
            end
            assign hit[gi] = arm[gi] && (slot_time_reg[gi] == cur_time[19:7]);
        end
    endgenerate

    assign seconds_zero = (cur_time[6:0] == 7'd0);
    // Only a fresh press counts; a held button never re-triggers.
    assign snooze_press = snooze && !snooze_prev_reg;
    assign ring_done    = tick_1hz && (sec_cnt_reg == RING_LAST);
    assign snooze_done  = tick_1hz && (sec_cnt_reg == SNOOZE_LAST);

    // Next-state logic: stop beats snooze, snooze beats a timeout.
    always_comb begin
        state_next = state_reg;
        slot_next  = slot_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ST_IDLE: begin
                if (tick_1hz && seconds_zero && (hit != 4'd0)) begin
                    state_next = ST_RING;
                    cnt_next   = 2'd0;
                    if (hit[0])      slot_next = 2'd0;
                    else if (hit[1]) slot_next = 2'd1;
                    else if (hit[2]) slot_next = 2'd2;
                    else             slot_next = 2'd3;
                end
            end
            ST_RING: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (snooze_press) begin
                    if (cnt_reg < SNOOZE_MAX) begin
                        state_next = ST_SNOOZE;
                        cnt_next   = cnt_reg + 2'd1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (ring_done) begin
`ifdef ALARM_SCHED_AUTO_SNOOZE_EN
                    if (cnt_reg < SNOOZE_MAX) begin
                        state_next = ST_SNOOZE;
                        cnt_next   = cnt_reg + 2'd1;
                    end else begin
                        state_next = ST_IDLE;
                    end
`else
                    state_next = ST_IDLE;
`endif
                end
            end
            ST_SNOOZE: begin
                if (stop) begin
                    state_next = ST_IDLE;
                end else if (snooze_done) begin
                    state_next = ST_RING;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Second counter restarts on every state change and is parked at 0 in IDLE.
    always_comb begin
        sec_cnt_next = sec_cnt_reg;
        if ((state_next != state_reg) || (state_reg == ST_IDLE)) begin
            sec_cnt_next = 10'd0;
        end else if (tick_1hz) begin
            sec_cnt_next = sec_cnt_reg + 10'd1;
        end
    end

    // State, counters and snooze edge detector.
    always_ff @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            state_reg       <= ST_IDLE;
            sec_cnt_reg     <= 10'd0;
            slot_reg        <= 2'd0;
            cnt_reg         <= 2'd0;
            snooze_prev_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            sec_cnt_reg     <= sec_cnt_next;
            slot_reg        <= slot_next;
            cnt_reg         <= cnt_next;
            snooze_prev_reg <= snooze;
        end
    end

    assign alarm       = (state_reg == ST_RING);
    assign busy        = (state_reg != ST_IDLE);
    assign active_slot = slot_reg;
    assign snooze_cnt  = cnt_reg;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Self-checking bench for alarm_scheduler: a behavioural model plus directed
// scenarios with literal expectations. Honours ALARM_SCHED_AUTO_SNOOZE_EN.
module tb_alarm_scheduler;

    localparam int RING = 60;
    localparam int SNZ  = 540;
    localparam int MAXS = 3;

    logic        clk      = 1'b0;
    logic        rst_bar  = 1'b1;
    logic        tick_1hz = 1'b0;
    logic [19:0] cur_time = 20'd0;
    logic        wr_en    = 1'b0;
    logic [1:0]  wr_slot  = 2'd0;
    logic [12:0] wr_hhmm  = 13'd0;
    logic [3:0]  arm      = 4'd0;
    logic        stop     = 1'b0;
    logic        snooze   = 1'b0;
    logic        alarm;
    logic [1:0]  active_slot;
    logic        busy;
    logic [1:0]  snooze_cnt;

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    alarm_scheduler #(
        .RING_SECS  (RING),
        .SNOOZE_SECS(SNZ),
        .MAX_SNOOZE (MAXS)
    ) dut (
        .clk        (clk),
        .rst_bar    (rst_bar),
        .tick_1hz   (tick_1hz),
        .cur_time   (cur_time),
        .wr_en      (wr_en),
        .wr_slot    (wr_slot),
        .wr_hhmm    (wr_hhmm),
        .arm        (arm),
        .stop       (stop),
        .snooze     (snooze),
        .alarm      (alarm),
        .active_slot(active_slot),
        .busy       (busy),
        .snooze_cnt (snooze_cnt)
    );

    // ---------------- behavioural model ----------------
    // phase: 0 = idle, 1 = ringing, 2 = snoozing; elapsed = whole seconds spent in phase
    int          m_phase   = 0;
    int          m_elapsed = 0;
    int          m_slot    = 0;
    int          m_cnt     = 0;
    bit          m_prev    = 1'b0;
    logic [12:0] m_slots [4] = '{default: 13'd0};

    task automatic m_idle();
        m_phase   = 0;
        m_elapsed = 0;
    endtask

    task automatic m_try_snooze();
        if (m_cnt < MAXS) begin
            m_phase   = 2;
            m_elapsed = 0;
            m_cnt     = m_cnt + 1;
        end else begin
            m_idle();
        end
    endtask

    always @(posedge clk or negedge rst_bar) begin
        if (!rst_bar) begin
            m_phase   = 0;
            m_elapsed = 0;
            m_slot    = 0;
            m_cnt     = 0;
            m_prev    = 1'b0;
            for (int n = 0; n < 4; n++) m_slots[n] = 13'd0;
        end else begin
            case (m_phase)
                0: begin
                    if (tick_1hz && (cur_time[6:0] == 7'd0)) begin
                        int found;
                        found = -1;
                        for (int n = 3; n >= 0; n--)
                            if (arm[n] && (m_slots[n] == cur_time[19:7])) found = n;
                        if (found >= 0) begin
                            m_phase   = 1;
                            m_elapsed = 0;
                            m_slot    = found;
                            m_cnt     = 0;
                        end
                    end
                end
                1: begin
                    if (stop) m_idle();
                    else if (snooze && !m_prev) m_try_snooze();
                    else if (tick_1hz) begin
                        if (m_elapsed == RING - 1) begin
`ifdef ALARM_SCHED_AUTO_SNOOZE_EN
                            m_try_snooze();
`else
                            m_idle();
`endif
                        end else m_elapsed = m_elapsed + 1;
                    end
                end
                default: begin
                    if (stop) m_idle();
                    else if (tick_1hz) begin
                        if (m_elapsed == SNZ - 1) begin
                            m_phase   = 1;
                            m_elapsed = 0;
                        end else m_elapsed = m_elapsed + 1;
                    end
                end
            endcase
            if (wr_en) m_slots[wr_slot] = wr_hhmm;
            m_prev = snooze;
        end
    end

    // Cycle-by-cycle compare of all outputs against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic [5:0] exp_v, act_v;
            exp_v = {m_phase == 1, m_phase != 0, 2'(m_slot), 2'(m_cnt)};
            act_v = {alarm, busy, active_slot, snooze_cnt};
            tests = tests + 1;
            if (act_v !== exp_v) begin
                fails = fails + 1;
                $display("FAIL model_cmp t=%0t {alarm,busy,slot,cnt} actual=%b required=%b",
                         $time, act_v, exp_v);
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests = tests + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [19:0] bcd(input int h, input int m, input int s);
        return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [12:0] hhmm(input int h, input int m);
        logic [19:0] t;
        t = bcd(h, m, 0);
        return t[19:7];
    endfunction

    task automatic clk1();
        @(posedge clk);
        #2;
    endtask

    task automatic do_tick();
        tick_1hz = 1'b1;
        clk1();
        tick_1hz = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            do_tick();
            clk1();
        end
    endtask

    task automatic wr(input logic [1:0] s, input logic [12:0] v);
        wr_en   = 1'b1;
        wr_slot = s;
        wr_hhmm = v;
        clk1();
        wr_en   = 1'b0;
    endtask

    task automatic press_snooze();
        snooze = 1'b1;
        clk1();
        snooze = 1'b0;
        clk1();
    endtask

    task automatic pulse_stop();
        stop = 1'b1;
        clk1();
        stop = 1'b0;
    endtask

    task automatic trigger(input int h, input int m);
        cur_time = bcd(h, m, 0);
        do_tick();
        cur_time = bcd(12, 0, 30);
    endtask

    // ---------------- directed scenarios ----------------
    initial begin
        #1 rst_bar = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_alarm", alarm, 0);
        check("rst_busy", busy, 0);
        check("rst_slot", active_slot, 0);
        check("rst_cnt", snooze_cnt, 0);
        rst_bar = 1'b1;
        cmp_en  = 1'b1;

        // No match without a tick even though every cleared slot equals 00:00.
        cur_time = bcd(0, 0, 0);
        arm      = 4'hF;
        repeat (3) clk1();
        check("no_match_without_tick", busy, 0);
        arm      = 4'h0;
        cur_time = bcd(12, 0, 30);
        clk1();

        // Slot 1 at 07:30.
        wr(2'd1, hhmm(7, 30));
        arm      = 4'b0010;
        cur_time = bcd(7, 29, 59);
        do_tick();
        check("pre_match_busy", busy, 0);
        clk1();
        trigger(7, 30);
        check("s1_alarm", alarm, 1);
        check("s1_slot", active_slot, 1);
        check("s1_busy", busy, 1);
        pulse_stop();

        // Two slots at 06:00 -> lowest index wins; stop ends the event.
        wr(2'd0, hhmm(6, 0));
        wr(2'd2, hhmm(6, 0));
        arm = 4'b0101;
        trigger(6, 0);
        check("tie_slot", active_slot, 0);
        check("tie_alarm", alarm, 1);
        pulse_stop();
        check("stop_alarm", alarm, 0);
        check("stop_busy", busy, 0);

        // Snooze sequence up to the limit, including a held button.
        clk1();
        trigger(6, 0);
        clk1();
        press_snooze();
        check("snz1_alarm", alarm, 0);
        check("snz1_cnt", snooze_cnt, 1);
        ticks(SNZ - 1);
        check("snz1_last_second_alarm", alarm, 0);
        check("snz1_last_second_busy", busy, 1);
        do_tick();
        check("snz1_back_ring", alarm, 1);
        clk1();
        snooze = 1'b1;
        clk1();
        check("snz2_cnt", snooze_cnt, 2);
        ticks(SNZ);
        check("snz2_back_ring", alarm, 1);
        clk1();
        clk1();
        check("held_no_retrigger_alarm", alarm, 1);
        check("held_no_retrigger_cnt", snooze_cnt, 2);
        snooze = 1'b0;
        clk1();
        press_snooze();
        check("snz3_cnt", snooze_cnt, 3);
        ticks(SNZ);
        check("snz3_back_ring", alarm, 1);
        press_snooze();
        check("snz4_idle_busy", busy, 0);
        check("snz4_cnt_held", snooze_cnt, 3);

        // stop and snooze together -> idle, count unchanged.
        trigger(6, 0);
        check("retrig_cnt_clear", snooze_cnt, 0);
        clk1();
        press_snooze();
        ticks(SNZ);
        check("both_pre_ring", alarm, 1);
        stop   = 1'b1;
        snooze = 1'b1;
        clk1();
        stop   = 1'b0;
        snooze = 1'b0;
        check("both_busy", busy, 0);
        check("both_cnt", snooze_cnt, 1);
        clk1();

        // Disarming / rewriting the owning slot keeps the event alive.
        trigger(6, 0);
        arm = 4'b0000;
        wr(2'd0, hhmm(8, 15));
        clk1();
        check("disarm_busy", busy, 1);
        check("disarm_alarm", alarm, 1);
        pulse_stop();

        // Unattended ring.
        arm = 4'b0001;
        trigger(8, 15);
        check("auto_start_slot", active_slot, 0);
        clk1();
`ifdef ALARM_SCHED_AUTO_SNOOZE_EN
        for (int r = 0; r < 4; r++) begin
            ticks(RING - 1);
            check("auto_ring_hold", alarm, 1);
            do_tick();
            if (r < 3) begin
                check("auto_silent", alarm, 0);
                check("auto_cnt", snooze_cnt, r + 1);
                clk1();
                ticks(SNZ - 1);
                do_tick();
                check("auto_reringing", alarm, 1);
                clk1();
            end else begin
                check("auto_final_busy", busy, 0);
                check("auto_final_cnt", snooze_cnt, 3);
            end
        end
`else
        ticks(RING - 1);
        check("timeout_last_second", alarm, 1);
        do_tick();
        check("timeout_busy", busy, 0);
        check("timeout_cnt", snooze_cnt, 0);
`endif
        clk1();

        // Asynchronous reset in the middle of a snooze.
        trigger(8, 15);
        clk1();
        press_snooze();
        ticks(5);
        check("pre_rst_busy", busy, 1);
        #1 rst_bar = 1'b0;
        #1;
        check("async_alarm", alarm, 0);
        check("async_busy", busy, 0);
        check("async_slot", active_slot, 0);
        check("async_cnt", snooze_cnt, 0);
        clk1();
        rst_bar = 1'b1;
        arm     = 4'b0001;
        clk1();
        trigger(0, 0);
        check("post_rst_alarm", alarm, 1);
        check("post_rst_slot", active_slot, 0);
        check("post_rst_busy", busy, 1);
        pulse_stop();
        clk1();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alarm_scheduler.md
ALARM_SCHEDULER -- requirements
Module: alarm_scheduler

Interface
REQ-001 Parameter RING_SECS, default 60, number of 1 Hz ticks one ring period lasts.
REQ-002 Parameter SNOOZE_SECS, default 540, number of 1 Hz ticks one silent snooze period lasts.
REQ-003 Parameter MAX_SNOOZE, default 3, maximum number of snooze periods per alarm event.
REQ-004 clk  input  1  system clock, 100 Hz.
REQ-005 rst_bar  input  1  reset; asynchronous, active-low.
REQ-006 tick_1hz  input  1  one-clk-wide strobe, once per second, coincident with the time-of-day update.
REQ-007 cur_time  input  20  current BCD time {h1[1:0],h0[3:0],m1[2:0],m0[3:0],s1[2:0],s0[3:0]}.
REQ-008 wr_en  input  1  write the alarm slot selected by wr_slot.
REQ-009 wr_slot  input  2  slot index, 0-3.
REQ-010 wr_hhmm  input  13  BCD alarm time {h1,h0,m1,m0}.
REQ-011 arm  input  4  per-slot enable; bit n arms slot n.
REQ-012 stop  input  1  level; ends the current alarm event.
REQ-013 snooze  input  1  level; silences the ring and starts a snooze period.
REQ-014 alarm  output  1  ringer drive.
REQ-015 active_slot  output  2  slot that owns the current event.
REQ-016 busy  output  1  high in RING or SNOOZE.
REQ-017 snooze_cnt  output  2  snooze periods started in the current event.

Function
REQ-018 Four 13-bit slot registers; wr_en loads wr_hhmm into slot wr_slot on that clk edge, in every state.
REQ-019 FSM states IDLE, RING, SNOOZE; alarm=1 only in RING; busy=1 in RING and SNOOZE.
REQ-020 Match: on tick_1hz in IDLE, slot n matches when arm[n]=1, slot hhmm equals cur_time hhmm, and cur_time seconds equal 00.
REQ-021 On a match: go to RING next edge; active_slot=lowest matching index; snooze_cnt=0; second counter=0.
REQ-022 Matches while in RING or SNOOZE are ignored, not queued.
REQ-023 The 10-bit second counter increments only on tick_1hz and clears on every state entry.
REQ-024 In RING, on the tick where counter=RING_SECS-1: ring timeout (see REQ-034).
REQ-025 In RING, snooze=1 with stop=0 and snooze_cnt<MAX_SNOOZE: enter SNOOZE and increment snooze_cnt.
REQ-026 In RING, snooze=1 with snooze_cnt=MAX_SNOOZE: go to IDLE.
REQ-027 In SNOOZE, on the tick where counter=SNOOZE_SECS-1: return to RING.
REQ-028 stop=1 in RING or SNOOZE: go to IDLE next edge; stop takes priority over snooze and timeouts in the same cycle.
REQ-029 snooze held high re-triggers only on its rising edge; one press counts as one snooze.
REQ-030 Clearing arm[active_slot] or rewriting that slot mid-event does not end the event.
REQ-031 active_slot and snooze_cnt hold their values in IDLE until the next match.

Reset
REQ-032 When rst_bar=0: state IDLE, alarm=0, busy=0, active_slot=0, snooze_cnt=0, counter=0, all slots 00:00, snooze edge detector cleared; this applies immediately, including mid-event.
REQ-033 After reset release, no match is evaluated before the first tick_1hz.

Configuration
REQ-034 Macro ALARM_SCHED_AUTO_SNOOZE_EN defined: a ring timeout with snooze_cnt<MAX_SNOOZE behaves as a snooze press, and with snooze_cnt=MAX_SNOOZE it goes to IDLE. Macro undefined: a ring timeout always goes to IDLE, and only an explicit snooze enters SNOOZE.

Verification
REQ-035 Write slot1=07:30, arm=0010, cur_time steps 07:29:59->07:30:00 with tick -> alarm=1, active_slot=1, busy=1 one clk later.
REQ-036 Slots 0 and 2 both 06:00 and armed, tick at 06:00:00 -> active_slot=0; stop=1 -> alarm=0, busy=0 next edge.
REQ-037 In RING, press snooze -> alarm=0, snooze_cnt=1; after 540 ticks -> alarm=1; a 4th press at snooze_cnt=3 -> IDLE.
REQ-038 AUTO_SNOOZE_EN defined, no user input -> alarm high 60 ticks, low 540 ticks, repeated; IDLE after the 4th ring. Undefined -> IDLE after 60 ticks.
REQ-039 stop and snooze asserted in the same cycle during RING -> IDLE, snooze_cnt unchanged.
REQ-040 rst_bar pulsed low mid-SNOOZE -> all outputs 0 asynchronously; the next 00:00:00 tick with arm=0001 -> RING on slot 0.
